fetch_unit: RTL
===============

# fetch_unit

Parametrised instruction-fetch front end that replaces the bare PC register and next-PC mux pair of the single-cycle core. Owns the fetch PC and drives a ready/valid request/response port to the instruction cache. Buffers returned instructions, each tagged with its PC, in a flushable queue feeding decode. Accepts branch/jump redirects from decode, with flush and discard of in-flight responses.

## Interface
- ADDR_W, 32, fetch address width
- DATA_W, 32, instruction width
- DEPTH, 4, queue entries; power of 2, ≥ 2
- RESET_PC, 32'h8002_0000, fetch PC after reset
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- ic_req  out  1  fetch request
- ic_addr  out  ADDR_W  request address, word aligned
- ic_ack  in  1  cache accepts request this cycle; meaningful only when ic_req=1
- ic_rvalid  in  1  response valid
- ic_rdata  in  DATA_W  response instruction
- redirect  in  1  branch/jump taken; one-cycle pulse
- redirect_pc  in  ADDR_W  target (pc+4+imm or target<<2, computed by decode)
- out_valid  out  1  instruction available
- out_instr  out  DATA_W  instruction
- out_pc  out  ADDR_W  PC of out_instr
- out_ready  in  1  decode accepts
- perf_stall_cnt  out  32  only with FETCH_PERF_EN
- perf_flush_cnt  out  32  only with FETCH_PERF_EN

## Operation
- State: fetch_pc, outstanding (0/1), req_pc, drop flag, queue (count 0..DEPTH).
- ic_req = !redirect && (!outstanding || ic_rvalid) && (count + outstanding < DEPTH). Combinational from registered state plus redirect/ic_rvalid.
- ic_addr = fetch_pc.
- Request handshake:
  - On ic_req && ic_ack: outstanding←1, req_pc←fetch_pc, fetch_pc←fetch_pc+4 (mod 2^ADDR_W; wraps silently).
  - Only one request outstanding at a time.
- Response handling:
  - On ic_rvalid with outstanding=1: outstanding←0 unless a new ack occurs in the same cycle.
  - If drop=0, push {req_pc, ic_rdata} into the queue. If drop=1, discard the response and clear drop.
  - ic_rvalid with outstanding=0 is ignored.
- Pop: on out_valid && out_ready. Push and pop in the same cycle are allowed, including at count=DEPTH-1/DEPTH. The space rule guarantees no overflow.
- Redirect (priority over everything):
  - Queue count←0 and fetch_pc←redirect_pc.
  - If outstanding=1 and no ic_rvalid this cycle: drop←1.
  - If ic_rvalid arrives in the redirect cycle, it is discarded.
  - out_valid is forced 0 in the redirect cycle. ic_req is 0, so no ack is possible.
- Misaligned redirect_pc: low 2 bits are forced to 0.
- Reset: fetch_pc←RESET_PC; outstanding, drop, count←0. Any response arriving after reset is ignored (outstanding=0).

## Timing
- Output values during reset: ic_req=0, out_valid=0, counters=0.
- First ic_req with ic_addr=RESET_PC is asserted in the first cycle after reset deasserts.
- Latency:
  - Ack in cycle N.
  - Earliest ic_rvalid in N+1.
  - Entry visible on out_valid in N+2 (registered queue, no bypass).
- Back-to-back fetch: the next request may be acked in the same cycle as the previous response. Sustained throughput is 1 instruction/cycle with a zero-wait cache and count+1 < DEPTH.
- Redirect in cycle R:
  - With no outstanding request, ic_req with redirect_pc is asserted in R+1.
  - With an outstanding request, it is asserted in the cycle of the dropped response.
- ic_addr is stable while ic_req=1 and ic_ack=0.

## Configuration
- FETCH_PERF_EN defined:
  - perf_stall_cnt increments each cycle with out_valid=0 and out_ready=1.
  - perf_flush_cnt increments per redirect.
  - Both counters saturate at 2^32-1 and clear on reset.
- FETCH_PERF_EN undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- fetch_pkg:
  - RESET_PC default.
  - fetch_entry_t {pc[ADDR_W], instr[DATA_W]}.
  - PC increment constant 4.
- Sub-module fetch_queue:
  - Synchronous FIFO, DEPTH entries.
  - Ports push, pop, flush, count, head.
  - Pointers wrap at DEPTH.
  - Flush has priority over push.
- Top level holds the PC/outstanding/drop logic and the perf counters.

## Test plan
- Reset, zero-wait cache returning addr^32'hFFFF_FFFF, out_ready=1 → out_pc sequence 8002_0000, 8002_0004, 8002_0008…, one per cycle from cycle 3.
- out_ready=0, DEPTH=4 → exactly 4 entries queued, ic_req low while count+outstanding=4. Release → 4 pops, fetch resumes at 8002_0010.
- Redirect to 8002_1000 while a request is outstanding with a 3-cycle cache delay → stale response discarded, next out_pc=8002_1000, no entry from the old stream.
- Redirect coincident with ic_rvalid and full queue → queue empties, out_valid=0 in that cycle, ic_req with 8002_1000 in the next cycle.
- fetch_pc=FFFF_FFFC (ADDR_W=32) → next request at 0000_0000; redirect_pc=0000_0103 → ic_addr 0000_0100.
- With FETCH_PERF_EN: 5 idle cycles with out_ready=1 and 2 redirects → perf_stall_cnt=5, perf_flush_cnt=2. Reset mid-run → both 0, ic_req at RESET_PC next cycle.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants.
// FETCH_PERF_EN enables the stall/flush counters in fetch_unit.
package fetch_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8002_0000;
    localparam int unsigned PC_INC = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Flushable synchronous FIFO of PC-tagged instructions.
// Flush wins over push; pointers wrap naturally at a power-of-2 depth.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type entry_t = fetch_entry_t,
    localparam int unsigned PW = $clog2(DEPTH),
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  entry_t        data,
    output logic [CW-1:0] count,
    output entry_t        head
);

    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    assign head = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push && !flush) mem[wr_ptr] <= data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, one-deep I$ request tracking, redirect flush.
// Define FETCH_PERF_EN to add saturating stall/flush performance counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clock,
    input  logic              reset,
    output logic              ic_req,
    output logic [ADDR_W-1:0] ic_addr,
    input  logic              ic_ack,
    input  logic              ic_rvalid,
    input  logic [DATA_W-1:0] ic_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    input  logic              out_ready
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_flush_cnt
`endif
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } entry_t;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] req_pc;
    logic              outstanding;
    logic              drop;
    logic [CW-1:0]     count;
    entry_t            head;
    entry_t            push_data;
    logic              space;
    logic              fire;
    logic              rsp;
    logic              push;
    logic              pop;

    // The in-flight request reserves a slot so its response can never overflow
    assign space = ({1'b0, count} + (CW+1)'(outstanding)) < (CW+1)'(DEPTH);
    assign ic_req = !reset && !redirect
                 && (!outstanding || ic_rvalid) && space;
    assign ic_addr = fetch_pc;
    assign fire = ic_req && ic_ack;
    assign rsp = outstanding && ic_rvalid;
    assign push = rsp && !drop && !redirect;
    assign push_data = '{pc: req_pc, instr: ic_rdata};

    assign out_valid = !reset && !redirect && (count != '0);
    assign pop = out_valid && out_ready;
    assign out_pc = head.pc;
    assign out_instr = head.instr;

    fetch_queue #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_queue (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .data  (push_data),
        .count (count),
        .head  (head)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            req_pc      <= '0;
            outstanding <= 1'b0;
            drop        <= 1'b0;
        end else if (redirect) begin
            fetch_pc    <= redirect_pc & ~ADDR_W'(3);
            // A response still in flight belongs to the old stream
            outstanding <= outstanding && !ic_rvalid;
            drop        <= outstanding && !ic_rvalid;
        end else begin
            if (rsp) begin
                outstanding <= 1'b0;
                drop        <= 1'b0;
            end
            if (fire) begin
                outstanding <= 1'b1;
                req_pc      <= fetch_pc;
                fetch_pc    <= fetch_pc + ADDR_W'(PC_INC);
            end
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (!out_valid && out_ready && perf_stall_cnt != '1)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (redirect && perf_flush_cnt != '1)
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule
